main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 74 +++++++
 tb/tb_main_control_fsm.sv | 132 +++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle LEGv8 control FSM sequencing fetch, decode, execute, memory and writeback
module main_control_fsm (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:21] ins,
  input  logic         imem_ack,
  input  logic         dmem_ack,
  input  logic         zero,
  output logic         imem_req,
  output logic         dmem_req,
  output logic [1:0]   ALUOp,
  output logic         ALUSrc,
  output logic         Reg2Loc,
  output logic         RegWrite,
  output logic         MemRead,
  output logic         MemWrite,
  output logic         MemToReg,
  output logic         SetFlags,
  output logic         IRWrite,
  output logic         PCWrite,
  output logic         PCSrc,
  output logic         illegal_op
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4;
  logic [2:0] state, nxt;
  logic [10:0] op;
  logic f, d, e, m, w;
  logic is_r, is_i, is_ld, is_st, is_cbz, is_b, is_flag, legal, br;
  assign f = state == FETCH;
  assign d = state == DECODE;
  assign e = state == EXEC;
  assign m = state == MEM;
  assign w = state == WB;
  assign is_r = op inside {11'b10001011000, 11'b10101011000, 11'b11001011000, 11'b11101011000,
                           11'b10001010000, 11'b10101010000, 11'b11001010000};
  assign is_i = op[10:1] inside {10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
                                 10'b1001001000, 10'b1011001000, 10'b1101001000};
  assign is_ld = op == 11'b11111000010;
  assign is_st = op == 11'b11111000000;
  assign is_cbz = op[10:3] == 8'b10110100;
  assign is_b = op[10:5] == 6'b000101;
  assign is_flag = op inside {11'b10101011000, 11'b11101011000} ||
                   op[10:1] inside {10'b1011000100, 10'b1111000100};
  assign legal = is_r | is_i | is_ld | is_st | is_cbz | is_b;
  assign br = e && (is_b || (is_cbz && zero));
  // reset gates every output so an in-flight handshake cannot leak a write
  assign imem_req = !reset && f;
  assign IRWrite = !reset && f && imem_ack;
  assign PCWrite = !reset && ((f && imem_ack) || br);
  assign PCSrc = !reset && br;
  assign illegal_op = !reset && d && !legal;
  assign ALUOp = (reset || !e) ? 2'b00 : (is_r | is_i) ? 2'b10 : (is_cbz | is_b) ? 2'b01 : 2'b00;
  assign ALUSrc = !reset && ((e && (is_i | is_ld | is_st)) || m);
  assign Reg2Loc = !reset && e && (is_st | is_cbz);
  assign SetFlags = !reset && e && is_flag;
  assign dmem_req = !reset && m;
  assign MemRead = !reset && m && is_ld;
  assign MemWrite = !reset && m && is_st;
  assign RegWrite = !reset && w;
  assign MemToReg = !reset && w && is_ld;
  assign nxt = f ? (imem_ack ? DECODE : FETCH) :
               d ? (legal ? EXEC : FETCH) :
               e ? ((is_ld | is_st) ? MEM : (is_r | is_i) ? WB : FETCH) :
               m ? (dmem_ack ? (is_ld ? WB : FETCH) : MEM) : FETCH;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      op <= 11'b0;
    end else begin
      state <= nxt;
      if (f && imem_ack) op <= ins;
    end
  end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: table-driven, scoreboard-checked bench for main_control_fsm
module tb_main_control_fsm;
  logic clk = 0, reset = 1, imem_ack = 0, dmem_ack = 0, zero = 0;
  logic [10:0] ins = 0;
  logic imem_req, dmem_req, ALUSrc, Reg2Loc, RegWrite, MemRead, MemWrite, MemToReg;
  logic SetFlags, IRWrite, PCWrite, PCSrc, illegal_op;
  logic [1:0] ALUOp;
  int checks = 0, fails = 0;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .ins(ins), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .zero(zero),
    .imem_req(imem_req), .dmem_req(dmem_req), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Reg2Loc(Reg2Loc),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .SetFlags(SetFlags), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // expected-output bit masks: {imem_req,dmem_req,ALUOp,ALUSrc,Reg2Loc,RegWrite,MemRead,MemWrite,MemToReg,SetFlags,IRWrite,PCWrite,PCSrc,illegal_op}
  localparam logic [14:0] IMR = 15'h4000, DMR = 15'h2000, A10 = 15'h1000, A01 = 15'h0800;
  localparam logic [14:0] ASRC = 15'h0400, R2L = 15'h0200, RW = 15'h0100, MR = 15'h0080;
  localparam logic [14:0] MW = 15'h0040, M2R = 15'h0020, SF = 15'h0010, IRW = 15'h0008;
  localparam logic [14:0] PCW = 15'h0004, PCS = 15'h0002, ILL = 15'h0001, NONE = 15'h0000;
  localparam logic [10:0] ADD = 11'b10001011000, LDUR = 11'b11111000010, STUR = 11'b11111000000;
  localparam logic [10:0] CBZ = 11'b10110100101, ADDIS = 11'b10110001001, BR = 11'b00010110011;
  localparam logic [10:0] SUBS = 11'b11101011000, EORI = 11'b11010010001, JUNK = 11'h7ff;

  typedef struct {
    int id;
    logic rst, ia, da, z;
    logic [10:0] op;
    logic [14:0] exp;
  } vec_t;
  vec_t vec[$];
  logic [14:0] exp_q[$];
  logic [14:0] got, want;

  task automatic add(input int id, input logic rst, input logic [10:0] op, input logic ia,
                     input logic da, input logic z, input logic [14:0] exp);
    vec.push_back('{id, rst, ia, da, z, op, exp});
  endtask

  task automatic step(input int id, input logic rst, input logic [10:0] op, input logic ia,
                      input logic da, input logic z, input logic [14:0] exp);
    @(posedge clk);
    #1;
    reset = rst; ins = op; imem_ack = ia; dmem_ack = da; zero = z;
    exp_q.push_back(exp);
    @(negedge clk);
    got = {imem_req, dmem_req, ALUOp, ALUSrc, Reg2Loc, RegWrite, MemRead, MemWrite, MemToReg,
           SetFlags, IRWrite, PCWrite, PCSrc, illegal_op};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL step %0d: outputs got %015b expected %015b", id, got, want);
    end
  endtask

  initial begin
    add(1, 1, ADD, 1, 1, 1, NONE);
    add(2, 1, ADD, 1, 0, 0, NONE);
    // ADD with immediate ack, junk ins and stray acks outside FETCH
    add(10, 0, ADD, 1, 0, 0, IMR | IRW | PCW);
    add(11, 0, JUNK, 0, 1, 0, NONE);
    add(12, 0, JUNK, 1, 1, 0, A10);
    add(13, 0, JUNK, 1, 1, 0, RW);
    add(14, 0, JUNK, 0, 0, 0, IMR);
    // LDUR with dmem_ack delayed 3 cycles
    add(20, 0, LDUR, 1, 0, 0, IMR | IRW | PCW);
    add(21, 0, JUNK, 0, 0, 0, NONE);
    add(22, 0, JUNK, 0, 0, 0, ASRC);
    add(23, 0, JUNK, 1, 0, 0, DMR | MR | ASRC);
    add(24, 0, JUNK, 0, 0, 0, DMR | MR | ASRC);
    add(25, 0, JUNK, 0, 0, 0, DMR | MR | ASRC);
    add(26, 0, JUNK, 0, 1, 0, DMR | MR | ASRC);
    add(27, 0, JUNK, 0, 0, 0, RW | M2R);
    add(28, 0, JUNK, 0, 0, 0, IMR);
    // CBZ taken then not taken
    add(30, 0, CBZ, 1, 0, 0, IMR | IRW | PCW);
    add(31, 0, JUNK, 0, 0, 1, NONE);
    add(32, 0, JUNK, 0, 0, 1, A01 | R2L | PCW | PCS);
    add(33, 0, JUNK, 0, 0, 0, IMR);
    add(34, 0, CBZ, 1, 0, 0, IMR | IRW | PCW);
    add(35, 0, JUNK, 0, 0, 0, NONE);
    add(36, 0, JUNK, 0, 0, 0, A01 | R2L);
    add(37, 0, JUNK, 0, 0, 0, IMR);
    // illegal opcode
    add(40, 0, 11'b0, 1, 0, 0, IMR | IRW | PCW);
    add(41, 0, JUNK, 0, 1, 1, ILL);
    add(42, 0, JUNK, 0, 0, 0, IMR);
    // ADDIS with imem_ack held low for 5 cycles
    for (int i = 0; i < 5; i++) add(50 + i, 0, ADDIS, 0, 0, 0, IMR);
    add(55, 0, ADDIS, 1, 0, 0, IMR | IRW | PCW);
    add(56, 0, JUNK, 0, 0, 0, NONE);
    add(57, 0, JUNK, 0, 0, 0, A10 | ASRC | SF);
    add(58, 0, JUNK, 0, 0, 0, RW);
    add(59, 0, JUNK, 0, 0, 0, IMR);
    // unconditional branch, flag-setting R and immediate logical ops
    add(60, 0, BR, 1, 0, 0, IMR | IRW | PCW);
    add(61, 0, JUNK, 0, 0, 0, NONE);
    add(62, 0, JUNK, 0, 0, 0, A01 | PCW | PCS);
    add(63, 0, SUBS, 1, 0, 0, IMR | IRW | PCW);
    add(64, 0, JUNK, 0, 0, 0, NONE);
    add(65, 0, JUNK, 0, 0, 0, A10 | SF);
    add(66, 0, JUNK, 0, 0, 0, RW);
    add(67, 0, EORI, 1, 0, 0, IMR | IRW | PCW);
    add(68, 0, JUNK, 0, 0, 0, NONE);
    add(69, 0, JUNK, 0, 0, 0, A10 | ASRC);
    add(70, 0, JUNK, 0, 0, 0, RW);
    // STUR completing normally
    add(80, 0, STUR, 1, 0, 0, IMR | IRW | PCW);
    add(81, 0, JUNK, 0, 0, 0, NONE);
    add(82, 0, JUNK, 0, 0, 0, ASRC | R2L);
    add(83, 0, JUNK, 0, 1, 0, DMR | MW | ASRC);
    add(84, 0, JUNK, 0, 0, 0, IMR);
    foreach (vec[i]) step(vec[i].id, vec[i].rst, vec[i].op, vec[i].ia, vec[i].da, vec[i].z, vec[i].exp);
    // STUR interrupted by reset in MEM together with dmem_ack
    step(90, 0, STUR, 1, 0, 0, IMR | IRW | PCW);
    step(91, 0, JUNK, 0, 0, 0, NONE);
    step(92, 0, JUNK, 0, 0, 0, ASRC | R2L);
    step(93, 0, JUNK, 0, 0, 0, DMR | MW | ASRC);
    step(94, 1, JUNK, 1, 1, 1, NONE);
    step(95, 1, JUNK, 1, 1, 1, NONE);
    step(96, 0, JUNK, 0, 0, 0, IMR);
    step(97, 0, ADD, 1, 0, 0, IMR | IRW | PCW);
    step(98, 0, JUNK, 0, 0, 0, NONE);
    step(99, 0, JUNK, 0, 0, 0, A10);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
